// File: rtl/exmem_skid_stage_if.sv
// EX/MEM handshake bundle: EX-side payload and valid/ready, MEM-side head entry,
// flush and stall counter. The environment drives through master, the stage through slave.
interface exmem_skid_stage_if #(
    parameter int WB_W   = 2,
    parameter int M_W    = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [WB_W-1:0]   WB_i;
    logic [M_W-1:0]    M_i;
    logic [DATA_W-1:0] ALU_output_i;
    logic [DATA_W-1:0] fw2_i;
    logic [REG_W-1:0]  reg_dst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WB_W-1:0]   WB_o;
    logic [M_W-1:0]    M_o;
    logic [DATA_W-1:0] ALU_output_o;
    logic [DATA_W-1:0] fw2_o;
    logic [REG_W-1:0]  reg_dst_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output flush_i, in_valid_i, WB_i, M_i, ALU_output_i, fw2_i, reg_dst_i, out_ready_i,
        input  in_ready_o, out_valid_o, WB_o, M_o, ALU_output_o, fw2_o, reg_dst_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, in_valid_i, WB_i, M_i, ALU_output_i, fw2_i, reg_dst_i, out_ready_i,
        output in_ready_o, out_valid_o, WB_o, M_o, ALU_output_o, fw2_o, reg_dst_o, stall_cnt_o
    );
endinterface

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register as a two-entry skid buffer with registered ready,
// NOP-zeroed control on bubbles, synchronous flush and a saturating stall counter.
//
// state | meaning
// EMPTY | no entry held (mv=0, sv=0)
// ONE   | head entry in main register (mv=1, sv=0)
// FULL  | head in main, next entry parked in skid (mv=1, sv=1)
module exmem_skid_stage #(
    parameter int WB_W   = 2,
    parameter int M_W    = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    exmem_skid_stage_if.slave   bus
);
    // State bits are {mv, sv} so the handshake outputs come straight off the flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] fw2;
        logic [REG_W-1:0]  reg_dst;
    } entry_t;

    state_t           state;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_e;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             push;
    logic             pop;

    assign in_e = '{wb: bus.WB_i, m: bus.M_i, alu: bus.ALU_output_i,
                    fw2: bus.fw2_i, reg_dst: bus.reg_dst_i};

    assign push = bus.in_valid_i & ~state[0];
    assign pop  = state[1] & bus.out_ready_i;

    // Control fields are cleared on every transition into EMPTY, so the
    // bubble NOP needs no output gating.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state[1] && !bus.out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);

            if (bus.flush_i) begin
                state    <= EMPTY;
                main_q.wb <= '0;
                main_q.m  <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (push) begin
                            main_q <= in_e;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_q <= in_e;
                        end else if (push) begin
                            skid_q <= in_e;
                            state  <= FULL;
                        end else if (pop) begin
                            state     <= EMPTY;
                            main_q.wb <= '0;
                            main_q.m  <= '0;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        main_q.wb <= '0;
                        main_q.m  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid_o  = state[1];
    assign bus.in_ready_o   = ~state[0];
    assign bus.WB_o         = main_q.wb;
    assign bus.M_o          = main_q.m;
    assign bus.ALU_output_o = main_q.alu;
    assign bus.fw2_o        = main_q.fw2;
    assign bus.reg_dst_o    = main_q.reg_dst;
    assign bus.stall_cnt_o  = stall_cnt_q;
endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: streaming, back-pressure, flush,
// bubble zeroing, stall-counter saturation and asynchronous reset.
module tb_exmem_skid_stage;
    localparam int WB_W   = 2;
    localparam int M_W    = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    exmem_skid_stage_if #(.WB_W(WB_W), .M_W(M_W), .DATA_W(DATA_W),
                          .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    exmem_skid_stage #(.WB_W(WB_W), .M_W(M_W), .DATA_W(DATA_W),
                       .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i      = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.WB_i         = '0;
        bus.M_i          = '0;
        bus.ALU_output_i = '0;
        bus.fw2_i        = '0;
        bus.reg_dst_i    = '0;
        bus.out_ready_i  = 1'b0;
    endtask

    task automatic set_in(input logic [1:0] wb, input logic [1:0] m,
                          input logic [31:0] alu, input logic [31:0] fw2,
                          input logic [4:0] rd);
        bus.in_valid_i   = 1'b1;
        bus.WB_i         = wb;
        bus.M_i          = m;
        bus.ALU_output_i = alu;
        bus.fw2_i        = fw2;
        bus.reg_dst_i    = rd;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_handshake: got valid=%b ready=%b, expected valid=0 ready=1",
                     bus.out_valid_o, bus.in_ready_o);
        end
        tests_run++;
        if ({bus.WB_o, bus.M_o, bus.ALU_output_o, bus.fw2_o, bus.reg_dst_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_payload: got wb=%h m=%h alu=%h fw2=%h rd=%h, expected all 0",
                     bus.WB_o, bus.M_o, bus.ALU_output_o, bus.fw2_o, bus.reg_dst_o);
        end
        tests_run++;
        if (bus.stall_cnt_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt_o);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            set_in(2'b10, 2'b01, 32'(i), 32'(i) << 8, 5'(i));
            step();
            tests_run++;
            if (bus.out_valid_o !== 1'b1 || bus.ALU_output_o !== 32'(i) ||
                bus.in_ready_o !== 1'b1 || bus.reg_dst_o !== 5'(i)) begin
                tests_failed++;
                $display("FAIL stream_%0d: got valid=%b alu=%h ready=%b rd=%0d, expected valid=1 alu=%h ready=1 rd=%0d",
                         i, bus.out_valid_o, bus.ALU_output_o, bus.in_ready_o, bus.reg_dst_o, i, i);
            end
        end
        bus.in_valid_i = 1'b0;
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.stall_cnt_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL stream_drain: got valid=%b stall=%0d, expected valid=0 stall=0",
                     bus.out_valid_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(2'b01, 2'b01, 32'hAAAA_0000, 32'h1111_1111, 5'd3);
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.ALU_output_o !== 32'hAAAA_0000 ||
            bus.in_ready_o !== 1'b1 || bus.stall_cnt_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL bp_push_a: got valid=%b alu=%h ready=%b stall=%0d, expected 1 aaaa0000 1 0",
                     bus.out_valid_o, bus.ALU_output_o, bus.in_ready_o, bus.stall_cnt_o);
        end
        set_in(2'b10, 2'b10, 32'hBBBB_0000, 32'h2222_2222, 5'd4);
        step();
        tests_run++;
        if (bus.in_ready_o !== 1'b0 || bus.ALU_output_o !== 32'hAAAA_0000 ||
            bus.stall_cnt_o !== 4'd1) begin
            tests_failed++;
            $display("FAIL bp_full: got ready=%b alu=%h stall=%0d, expected ready=0 alu=aaaa0000 stall=1",
                     bus.in_ready_o, bus.ALU_output_o, bus.stall_cnt_o);
        end
        bus.in_valid_i = 1'b0;
        step();
        tests_run++;
        if (bus.ALU_output_o !== 32'hAAAA_0000 || bus.stall_cnt_o !== 4'd2 ||
            bus.in_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: got alu=%h stall=%0d ready=%b, expected alu=aaaa0000 stall=2 ready=0",
                     bus.ALU_output_o, bus.stall_cnt_o, bus.in_ready_o);
        end
        bus.out_ready_i = 1'b1;
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.ALU_output_o !== 32'hBBBB_0000 ||
            bus.fw2_o !== 32'h2222_2222 || bus.WB_o !== 2'b10 || bus.reg_dst_o !== 5'd4 ||
            bus.in_ready_o !== 1'b1 || bus.stall_cnt_o !== 4'd2) begin
            tests_failed++;
            $display("FAIL bp_pop_a: got valid=%b alu=%h fw2=%h wb=%b rd=%0d ready=%b stall=%0d, expected 1 bbbb0000 22222222 10 4 1 2",
                     bus.out_valid_o, bus.ALU_output_o, bus.fw2_o, bus.WB_o, bus.reg_dst_o,
                     bus.in_ready_o, bus.stall_cnt_o);
        end
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.WB_o !== 2'b00 || bus.M_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_pop_b: got valid=%b wb=%b m=%b, expected valid=0 wb=00 m=00",
                     bus.out_valid_o, bus.WB_o, bus.M_o);
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(2'b01, 2'b01, 32'hAAAA_0000, 32'h0, 5'd1);
        step();
        set_in(2'b10, 2'b10, 32'hBBBB_0000, 32'h0, 5'd2);
        step();
        set_in(2'b11, 2'b11, 32'hCCCC_0000, 32'h0, 5'd5);
        bus.flush_i = 1'b1;
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.WB_o !== 2'b00 || bus.M_o !== 2'b00 ||
            bus.in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_state: got valid=%b wb=%b m=%b ready=%b, expected 0 00 00 1",
                     bus.out_valid_o, bus.WB_o, bus.M_o, bus.in_ready_o);
        end
        tests_run++;
        if (bus.stall_cnt_o !== 4'd2) begin
            tests_failed++;
            $display("FAIL flush_stall_cnt: got %0d expected 2", bus.stall_cnt_o);
        end
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus.out_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_c_%0d: got valid=%b alu=%h, expected valid=0",
                         i, bus.out_valid_o, bus.ALU_output_o);
            end
        end
    endtask

    task automatic test_bubble();
        do_reset();
        bus.out_ready_i = 1'b1;
        set_in(2'b11, 2'b10, 32'h1234_5678, 32'h0, 5'd7);
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.WB_o !== 2'b11 || bus.M_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL bubble_entry: got valid=%b wb=%b m=%b, expected 1 11 10",
                     bus.out_valid_o, bus.WB_o, bus.M_o);
        end
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bus.out_valid_o !== 1'b0 || bus.WB_o !== 2'b00 || bus.M_o !== 2'b00) begin
                tests_failed++;
                $display("FAIL bubble_zero_%0d: got valid=%b wb=%b m=%b, expected 0 00 00",
                         i, bus.out_valid_o, bus.WB_o, bus.M_o);
            end
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(2'b01, 2'b00, 32'h5, 32'h0, 5'd1);
        step();
        bus.in_valid_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14 || k == 15 || k == 20) begin
                tests_run++;
                if (bus.stall_cnt_o !== ((k > 15) ? 4'd15 : 4'(k))) begin
                    tests_failed++;
                    $display("FAIL stall_sat_%0d: got %0d expected %0d",
                             k, bus.stall_cnt_o, (k > 15) ? 15 : k);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(2'b01, 2'b01, 32'hAAAA_0000, 32'h3, 5'd1);
        step();
        set_in(2'b10, 2'b10, 32'hBBBB_0000, 32'h4, 5'd2);
        step();
        bus.in_valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.WB_o !== 2'b00 ||
            bus.ALU_output_o !== 32'h0 || bus.stall_cnt_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b ready=%b wb=%b alu=%h stall=%0d, expected 0 1 00 0 0",
                     bus.out_valid_o, bus.in_ready_o, bus.WB_o, bus.ALU_output_o, bus.stall_cnt_o);
        end
        step();
        rst = 1'b1;
        set_in(2'b11, 2'b01, 32'hDDDD_0000, 32'h5, 5'd9);
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.ALU_output_o !== 32'hDDDD_0000 ||
            bus.in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_first_push: got valid=%b alu=%h ready=%b, expected 1 dddd0000 1",
                     bus.out_valid_o, bus.ALU_output_o, bus.in_ready_o);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        tests_run++;
        if (bus.out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_skid_dropped: got valid=%b alu=%h, expected valid=0",
                     bus.out_valid_o, bus.ALU_output_o);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush_full();
        test_bubble();
        test_counter_sat();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
